mask_stream: RTL and testbench



---
 rtl/mask_stream.sv | 253 +++++++++++++++++++++++++
 tb/tb_mask_stream.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_stream.sv
// mask_stream: per-channel bitwise mask (AND/OR/XOR/AND-NOT) on a valid/ready stream,
// one register stage into a DEPTH-entry output FIFO, with saturating transfer statistics.
// Optional MASK_STREAM_POPCOUNT_EN adds out_pop, the ones-count of out_data.
module mask_stream #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_ch,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_ch,
    output logic             out_zero,
    input  logic             cnt_clr,
    output logic [31:0]      count_xfer,
    output logic [31:0]      count_zero,
`ifdef MASK_STREAM_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] out_pop,
`endif
    output logic             err_ch
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
`ifdef MASK_STREAM_POPCOUNT_EN
    localparam int PW   = $clog2(WIDTH + 1);
`endif

    function automatic logic ch_in_range(input logic [CW-1:0] ch);
        return ({{(32-CW){1'b0}}, ch} < 32'(CHANNELS));
    endfunction

    function automatic logic [WIDTH-1:0] apply_mask(input logic [WIDTH-1:0] d,
                                                     input logic [WIDTH-1:0] m,
                                                     input logic [1:0]       mode);
        logic [WIDTH-1:0] r;
        case (mode)
            2'd0:    r = d & m;
            2'd1:    r = d | m;
            2'd2:    r = d ^ m;
            default: r = d & ~m;
        endcase
        return r;
    endfunction

`ifdef MASK_STREAM_POPCOUNT_EN
    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] n;
        n = {PW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction
`endif

    logic [WIDTH-1:0] mask_q [CHANNELS];
    logic [WIDTH-1:0] mask_d [CHANNELS];

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [CW-1:0]    s1_ch_q,    s1_ch_d;
    logic             s1_zero_q,  s1_zero_d;

    logic [WIDTH-1:0] mem_data_q [DEPTH];
    logic [WIDTH-1:0] mem_data_d [DEPTH];
    logic [CW-1:0]    mem_ch_q   [DEPTH];
    logic [CW-1:0]    mem_ch_d   [DEPTH];
    logic             mem_zero_q [DEPTH];
    logic             mem_zero_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q,  count_d;

    logic [31:0]      count_xfer_q, count_xfer_d;
    logic [31:0]      count_zero_q, count_zero_d;
    logic             err_ch_q,     err_ch_d;

`ifdef MASK_STREAM_POPCOUNT_EN
    logic [PW-1:0]    s1_pop_q, s1_pop_d;
    logic [PW-1:0]    mem_pop_q [DEPTH];
    logic [PW-1:0]    mem_pop_d [DEPTH];
`endif

    logic             accept_s;
    logic             ch_ok_s;
    logic [WIDTH-1:0] mask_sel_s;
    logic [WIDTH-1:0] result_s;
    logic             push_s;
    logic             pop_s;

    // Space check counts the word already in stage 1, so every stage-1 word has a FIFO slot.
    assign in_ready  = ({1'b0, count_q} + {{CNTW{1'b0}}, s1_valid_q}) < (CNTW+1)'(DEPTH);
    assign out_valid = (count_q != {CNTW{1'b0}});
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_ch    = mem_ch_q[rd_ptr_q];
    assign out_zero  = mem_zero_q[rd_ptr_q];
`ifdef MASK_STREAM_POPCOUNT_EN
    assign out_pop   = mem_pop_q[rd_ptr_q];
`endif
    assign count_xfer = count_xfer_q;
    assign count_zero = count_zero_q;
    assign err_ch     = err_ch_q;

    // Mask bank update; out-of-range addresses are dropped.
    always_comb begin
        mask_d = mask_q;
        if (cfg_we && ch_in_range(cfg_addr)) begin
            mask_d[cfg_addr] = cfg_data;
        end else begin
            mask_d = mask_q;
        end
    end

    // Stage 1: mask reads the pre-write bank value, so a same-edge write affects only later words.
    always_comb begin
        accept_s   = in_valid && in_ready;
        ch_ok_s    = ch_in_range(in_ch);
        mask_sel_s = ch_ok_s ? mask_q[in_ch] : {WIDTH{1'b1}};
        result_s   = apply_mask(in_data, mask_sel_s, in_mode);
        s1_valid_d = accept_s;
        s1_data_d  = s1_data_q;
        s1_ch_d    = s1_ch_q;
        s1_zero_d  = s1_zero_q;
`ifdef MASK_STREAM_POPCOUNT_EN
        s1_pop_d   = s1_pop_q;
`endif
        if (accept_s) begin
            s1_data_d = result_s;
            s1_ch_d   = in_ch;
            s1_zero_d = (result_s == {WIDTH{1'b0}});
`ifdef MASK_STREAM_POPCOUNT_EN
            s1_pop_d  = popcount(result_s);
`endif
        end else begin
            s1_data_d = s1_data_q;
        end
        err_ch_d = err_ch_q | (accept_s & ~ch_ok_s);
    end

    // Output FIFO: stage 1 always pushes the edge after it loads; head pops on transfer.
    always_comb begin
        push_s     = s1_valid_q;
        pop_s      = out_valid && out_ready;
        mem_data_d = mem_data_q;
        mem_ch_d   = mem_ch_q;
        mem_zero_d = mem_zero_q;
`ifdef MASK_STREAM_POPCOUNT_EN
        mem_pop_d  = mem_pop_q;
`endif
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            mem_data_d[wr_ptr_q] = s1_data_q;
            mem_ch_d[wr_ptr_q]   = s1_ch_q;
            mem_zero_d[wr_ptr_q] = s1_zero_q;
`ifdef MASK_STREAM_POPCOUNT_EN
            mem_pop_d[wr_ptr_q]  = s1_pop_q;
`endif
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNTW'(1'b1);
            2'b01:   count_d = count_q - CNTW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Saturating statistics; clear wins over a same-edge increment.
    always_comb begin
        count_xfer_d = count_xfer_q;
        count_zero_d = count_zero_q;
        if (cnt_clr) begin
            count_xfer_d = 32'd0;
            count_zero_d = 32'd0;
        end else if (pop_s) begin
            if (count_xfer_q != {32{1'b1}}) begin
                count_xfer_d = count_xfer_q + 32'd1;
            end else begin
                count_xfer_d = count_xfer_q;
            end
            if (out_zero && (count_zero_q != {32{1'b1}})) begin
                count_zero_d = count_zero_q + 32'd1;
            end else begin
                count_zero_d = count_zero_q;
            end
        end else begin
            count_xfer_d = count_xfer_q;
        end
    end

    // State registers; storage is cleared too so out_data is never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q       <= '{default: {WIDTH{1'b1}}};
            s1_valid_q   <= 1'b0;
            s1_data_q    <= {WIDTH{1'b0}};
            s1_ch_q      <= {CW{1'b0}};
            s1_zero_q    <= 1'b0;
            mem_data_q   <= '{default: {WIDTH{1'b0}}};
            mem_ch_q     <= '{default: {CW{1'b0}}};
            mem_zero_q   <= '{default: 1'b0};
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CNTW{1'b0}};
            count_xfer_q <= 32'd0;
            count_zero_q <= 32'd0;
            err_ch_q     <= 1'b0;
`ifdef MASK_STREAM_POPCOUNT_EN
            s1_pop_q     <= {PW{1'b0}};
            mem_pop_q    <= '{default: {PW{1'b0}}};
`endif
        end else begin
            mask_q       <= mask_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_ch_q      <= s1_ch_d;
            s1_zero_q    <= s1_zero_d;
            mem_data_q   <= mem_data_d;
            mem_ch_q     <= mem_ch_d;
            mem_zero_q   <= mem_zero_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            count_xfer_q <= count_xfer_d;
            count_zero_q <= count_zero_d;
            err_ch_q     <= err_ch_d;
`ifdef MASK_STREAM_POPCOUNT_EN
            s1_pop_q     <= s1_pop_d;
            mem_pop_q    <= mem_pop_d;
`endif
        end
    end

endmodule

// File: tb/tb_mask_stream.sv
// Bench for mask_stream (CHANNELS=3 so an out-of-range channel can be driven):
// table-driven vectors plus hand sequences, checked through an expected-output queue.
module tb_mask_stream;

    localparam int W  = 16;
    localparam int CH = 3;
    localparam int DP = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [CW-1:0] cfg_addr;
    logic [W-1:0]  cfg_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [CW-1:0] in_ch;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_ch;
    logic          out_zero;
    logic          cnt_clr;
    logic [31:0]   count_xfer;
    logic [31:0]   count_zero;
    logic          err_ch;
`ifdef MASK_STREAM_POPCOUNT_EN
    logic [$clog2(W+1)-1:0] out_pop;
`endif

    always #5 clk = ~clk;

    mask_stream #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ch(in_ch), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_zero(out_zero),
        .cnt_clr(cnt_clr), .count_xfer(count_xfer), .count_zero(count_zero),
`ifdef MASK_STREAM_POPCOUNT_EN
        .out_pop(out_pop),
`endif
        .err_ch(err_ch)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] ch;
        logic          zero;
    } exp_t;

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] ch;
        logic [1:0]    mode;
        logic [W-1:0]  exp_d;
    } vec_t;

    exp_t  sb_q[$];
    vec_t  tbl[6];
    int    n_checks = 0;
    int    n_errors = 0;
    logic [31:0] exp_xfer = 32'd0;
    logic [31:0] exp_zero = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Output side: compare each transfer against the queue and model the counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: actual=%h required=none", out_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_data", {16'h0, out_data}, {16'h0, e.data});
                    check("out_ch",   {30'h0, out_ch},   {30'h0, e.ch});
                    check("out_zero", {31'h0, out_zero}, {31'h0, e.zero});
                    if (!cnt_clr) begin
                        if (exp_xfer != 32'hFFFF_FFFF) exp_xfer = exp_xfer + 32'd1;
                        if (e.zero && exp_zero != 32'hFFFF_FFFF) exp_zero = exp_zero + 32'd1;
                    end
                end
            end
            if (cnt_clr) begin
                exp_xfer = 32'd0;
                exp_zero = 32'd0;
            end
        end
    end

    // Offer one word; expectation is queued on the edge that accepts it.
    task automatic send(input logic [W-1:0] d, input logic [CW-1:0] ch,
                        input logic [1:0] mode, input logic [W-1:0] exp_d);
        int waited;
        in_data  = d;
        in_ch    = ch;
        in_mode  = mode;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: actual=no_accept required=accept data=%h", d);
        end else begin
            sb_q.push_back('{exp_d, ch, (exp_d == 16'h0000)});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_write(input logic [CW-1:0] a, input logic [W-1:0] d);
        cfg_addr = a;
        cfg_data = d;
        cfg_we   = 1'b1;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{16'hFFFF, 2'd2, 2'd0, 16'h0F0F};
        tbl[1] = '{16'hFFFF, 2'd2, 2'd1, 16'hFFFF};
        tbl[2] = '{16'hFFFF, 2'd2, 2'd2, 16'hF0F0};
        tbl[3] = '{16'hFFFF, 2'd2, 2'd3, 16'hF0F0};
        tbl[4] = '{16'h1234, 2'd0, 2'd2, 16'hEDCB};
        tbl[5] = '{16'h00FF, 2'd0, 2'd3, 16'h0000};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; in_ch = '0; in_mode = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        wait_cycles(2);
        check("rst_out_valid",  {31'h0, out_valid}, 32'd0);
        check("rst_out_data",   {16'h0, out_data},  32'd0);
        check("rst_count_xfer", count_xfer,         32'd0);
        check("rst_count_zero", count_zero,         32'd0);
        check("rst_err_ch",     {31'h0, err_ch},    32'd0);
        rst = 1'b0;
        wait_cycles(1);
        check("in_ready_after_rst", {31'h0, in_ready}, 32'd1);

        // Single word, latency of two edges from accept to transfer.
        out_ready = 1'b1;
        send(16'hABCD, 2'd0, 2'd0, 16'hABCD);
        check("latency_not_yet", {31'h0, out_valid}, 32'd0);
        wait_cycles(1);
        check("latency_valid", {31'h0, out_valid}, 32'd1);
        check("latency_data",  {16'h0, out_data},  32'h0000_ABCD);
        wait_cycles(1);
        check("xfer_first", count_xfer, 32'd1);

        // Table: all four modes on mask 0F0F, plus ch0 patterns.
        cfg_write(2'd2, 16'h0F0F);
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data, tbl[i].ch, tbl[i].mode, tbl[i].exp_d);
        end
        wait_cycles(4);
        check("table_xfer", count_xfer, 32'd7);
        check("table_zero", count_zero, 32'd1);
        check("table_sb_empty", sb_q.size(), 32'd0);

        // Backpressure: four fill the FIFO, the rest wait for the drain.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(16'h1111 * (i + 1), 2'd0, 2'd0, 16'h1111 * (i + 1));
        end
        fork
            begin
                send(16'h5555, 2'd0, 2'd0, 16'h5555);
                send(16'h6666, 2'd0, 2'd0, 16'h6666);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("full_in_ready",  {31'h0, in_ready},  32'd0);
                    check("full_out_valid", {31'h0, out_valid}, 32'd1);
                    check("full_hold_data", {16'h0, out_data},  32'h0000_1111);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_cycles(4);
        check("bp_xfer", count_xfer, 32'd13);
        check("bp_sb_empty", sb_q.size(), 32'd0);

        // Same-edge mask write uses the old mask; the next word sees the new one.
        cfg_addr = 2'd1; cfg_data = 16'h0000; cfg_we = 1'b1;
        send(16'h1234, 2'd1, 2'd0, 16'h1234);
        send(16'h5678, 2'd1, 2'd0, 16'h0000);
        wait_cycles(4);
        check("rbw_zero", count_zero, 32'd2);
        check("rbw_xfer", count_xfer, 32'd15);

        // Out-of-range write ignored; out-of-range channel passes data and sets err_ch.
        cfg_write(2'd3, 16'h0000);
        send(16'h5555, 2'd3, 2'd0, 16'h5555);
        check("err_ch_set", {31'h0, err_ch}, 32'd1);
        send(16'hAAAA, 2'd0, 2'd0, 16'hAAAA);
        wait_cycles(4);
        check("err_xfer", count_xfer, 32'd17);
        check("err_ch_sticky", {31'h0, err_ch}, 32'd1);

        // Saturation from a preloaded counter.
        @(negedge clk);
        force dut.count_xfer_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_xfer_q;
        exp_xfer = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        send(16'h0101, 2'd0, 2'd0, 16'h0101);
        send(16'h0202, 2'd0, 2'd0, 16'h0202);
        wait_cycles(4);
        check("sat_xfer", count_xfer, 32'hFFFF_FFFF);
        check("sat_model", count_xfer, exp_xfer);
        check("sat_zero", count_zero, 32'd2);

        // Clear coincident with a transfer.
        out_ready = 1'b0;
        send(16'h0F00, 2'd0, 2'd0, 16'h0F00);
        wait_cycles(1);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        wait_cycles(1);
        cnt_clr   = 1'b0;
        check("clr_xfer", count_xfer, 32'd0);
        check("clr_zero", count_zero, 32'd0);
        send(16'h0000, 2'd0, 2'd0, 16'h0000);
        wait_cycles(4);
        check("post_clr_xfer", count_xfer, 32'd1);
        check("post_clr_zero", count_zero, 32'd1);

        // Asynchronous reset mid-stream flushes everything and restores masks.
        out_ready = 1'b0;
        send(16'h5555, 2'd3, 2'd0, 16'h5555);
        send(16'h1111, 2'd2, 2'd0, 16'h0101);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'h0, out_valid}, 32'd0);
        check("arst_err_ch",    {31'h0, err_ch},    32'd0);
        check("arst_xfer",      count_xfer,         32'd0);
        check("arst_in_ready",  {31'h0, in_ready},  32'd1);
        sb_q.delete();
        exp_xfer = 32'd0;
        exp_zero = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(16'hFFFF, 2'd2, 2'd0, 16'hFFFF);
        wait_cycles(4);
        check("post_rst_xfer", count_xfer, 32'd1);
        check("post_rst_sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
